// File: rtl/pla_seq_pkg.sv
// Shared types and helpers for the programmable pipelined PLA evaluator.
package pla_seq_pkg;

    typedef enum logic [1:0] {
        OP_WR_CUBE = 2'b00,
        OP_WR_POL  = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_INVAL   = 2'b11
    } cfg_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pla_cube_match.sv
// Match logic for a single product term: every cared-for input must equal its polarity bit.
module pla_cube_match #(
    parameter int NUM_IN = 16
) (
    input  logic              valid,
    input  logic [NUM_IN-1:0] care,
    input  logic [NUM_IN-1:0] pol,
    input  logic [NUM_IN-1:0] data,
    output logic              match
);

    assign match = valid & (&(~care | ~(data ^ pol)));

endmodule

// File: rtl/pla_seq_eval.sv
// Run-time programmable sum-of-products evaluator with a 2-stage valid/ready pipeline
// and a per-result matched-cube count.
module pla_seq_eval
    import pla_seq_pkg::*;
#(
    parameter  int NUM_IN    = 16,
    parameter  int NUM_OUT   = 8,
    parameter  int NUM_CUBES = 32,
    localparam int AW        = (clog2(NUM_CUBES) > 1) ? clog2(NUM_CUBES) : 1,
    localparam int CW        = clog2(NUM_CUBES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_data,
    output logic [CW-1:0]      out_match_cnt,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_op,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [NUM_IN-1:0]  cfg_care,
    input  logic [NUM_IN-1:0]  cfg_pol,
    input  logic [NUM_OUT-1:0] cfg_omask,
    output logic               cfg_err,
    output logic               busy
);

    cfg_op_e              op;
    state_e               state_q, state_d;
    logic [AW-1:0]        clr_idx_q, clr_idx_d;
    logic                 cube_valid [NUM_CUBES];
    logic [NUM_IN-1:0]    cube_care  [NUM_CUBES];
    logic [NUM_IN-1:0]    cube_pol   [NUM_CUBES];
    logic [NUM_OUT-1:0]   cube_omask [NUM_CUBES];
    logic [NUM_OUT-1:0]   out_pol;
    logic [NUM_CUBES-1:0] match_now, s1_match;
    logic                 s1_valid, stall, s1_en, in_fire, cfg_fire, addr_ok;
    logic [NUM_OUT-1:0]   or_vec;
    logic [CW-1:0]        hit_cnt;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // Config is only taken with an empty pipeline and always wins over a new input.
    assign op        = cfg_op_e'(cfg_op);
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = (state_q == ST_RUN) & ~cfg_valid & ~(stall & s1_valid);
    assign cfg_ready = (state_q == ST_RUN) & ~s1_valid & ~out_valid;
    assign in_fire   = in_valid & in_ready;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign s1_en     = ~stall | ~s1_valid;
    assign busy      = (state_q == ST_CLEAR);
    assign addr_ok   = (int'(cfg_addr) < NUM_CUBES);

    for (genvar i = 0; i < NUM_CUBES; i++) begin : g_cube
        pla_cube_match #(.NUM_IN(NUM_IN)) u_match (
            .valid (cube_valid[i]),
            .care  (cube_care[i]),
            .pol   (cube_pol[i]),
            .data  (in_data),
            .match (match_now[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_RUN: begin
                if (cfg_fire && op == OP_CLEAR) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_q == AW'(NUM_CUBES - 1)) state_d = ST_RUN;
                else clr_idx_d = clr_idx_q + 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Out-of-range addresses match no index, so the table stays untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CUBES; i++) begin
                cube_valid[i] <= 1'b0;
                cube_care[i]  <= '0;
                cube_pol[i]   <= '0;
                cube_omask[i] <= '0;
            end
            out_pol <= '0;
            cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CUBES; i++) begin
                if (busy && clr_idx_q == AW'(i)) begin
                    cube_valid[i] <= 1'b0;
                end else if (cfg_fire && cfg_addr == AW'(i)) begin
                    if (op == OP_WR_CUBE) begin
                        cube_valid[i] <= 1'b1;
                        cube_care[i]  <= cfg_care;
                        cube_pol[i]   <= cfg_pol;
                        cube_omask[i] <= cfg_omask;
                    end else if (op == OP_INVAL) begin
                        cube_valid[i] <= 1'b0;
                    end
                end
            end
            if (cfg_fire && op == OP_WR_POL) out_pol <= cfg_omask;
            cfg_err <= cfg_fire & (op == OP_WR_CUBE || op == OP_INVAL) & ~addr_ok;
        end
    end

    always_comb begin
        or_vec  = '0;
        hit_cnt = '0;
        for (int i = 0; i < NUM_CUBES; i++) begin
            if (s1_match[i]) begin
                or_vec  = or_vec | cube_omask[i];
                hit_cnt = hit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_match      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_match_cnt <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_fire;
                if (in_fire) s1_match <= match_now;
            end
            if (!stall) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data      <= or_vec ^ out_pol;
                    out_match_cnt <= hit_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Directed bench for pla_seq_eval: vector table per phase, scoreboard on the result stream,
// hand sequences for backpressure, CLEAR, reset and address errors.
`timescale 1ns/1ps
module tb_pla_seq_eval;

    localparam int NI  = 16;
    localparam int NO  = 8;
    localparam int CWA = 6;
    localparam int CWB = 5;
    localparam int W   = NO + CWA;
    localparam int NV  = 14;

    typedef struct {
        int          phase;
        logic [15:0] data;
        logic [7:0]  exp_out;
        logic [5:0]  exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic           in_valid = 1'b0, out_ready = 1'b1, cfg_valid = 1'b0;
    logic           in_ready, out_valid, cfg_ready, cfg_err, busy;
    logic [NI-1:0]  in_data = '0, cfg_care = '0, cfg_pol = '0;
    logic [NO-1:0]  out_data, cfg_omask = '0;
    logic [CWA-1:0] out_match_cnt;
    logic [1:0]     cfg_op = 2'b00;
    logic [4:0]     cfg_addr = '0;

    logic           b_in_valid = 1'b0, b_out_ready = 1'b1, b_cfg_valid = 1'b0;
    logic           b_in_ready, b_out_valid, b_cfg_ready, b_cfg_err, b_busy;
    logic [NI-1:0]  b_in_data = '0, b_cfg_care = '0, b_cfg_pol = '0;
    logic [NO-1:0]  b_out_data, b_cfg_omask = '0;
    logic [CWB-1:0] b_out_match_cnt;
    logic [1:0]     b_cfg_op = 2'b00;
    logic [4:0]     b_cfg_addr = '0;

    logic [W-1:0] exp_q[$];
    vec_t         vecs [NV];
    int checks = 0, errors = 0, cyc = 0, rx_cnt = 0, err_pulses = 0, b_err_pulses = 0;
    int busy_cnt, blk_bad, rx0;

    pla_seq_eval #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_CUBES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_match_cnt(out_match_cnt),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_addr(cfg_addr),
        .cfg_care(cfg_care), .cfg_pol(cfg_pol), .cfg_omask(cfg_omask),
        .cfg_err(cfg_err), .busy(busy)
    );

    pla_seq_eval #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_CUBES(24)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_match_cnt(b_out_match_cnt),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_op(b_cfg_op), .cfg_addr(b_cfg_addr),
        .cfg_care(b_cfg_care), .cfg_pol(b_cfg_pol), .cfg_omask(b_cfg_omask),
        .cfg_err(b_cfg_err), .busy(b_busy)
    );

    // Clock, cycle counter and watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted result is compared against the next expected entry.
    always @(negedge clk) begin
        if (rst_n && cfg_err) err_pulses++;
        if (rst_n && b_cfg_err) b_err_pulses++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: actual=0x%0h expected=none", {out_data, out_match_cnt});
            end else begin
                chk("sb_result", {out_data, out_match_cnt}, exp_q.pop_front());
                rx_cnt++;
            end
        end
    end

    task automatic send_vec(input logic [15:0] d, input logic [7:0] eo, input logic [5:0] ec);
        int n;
        n = 0;
        exp_q.push_back({eo, ec});
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_timeout: actual=in_ready 0 expected=1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic cfg_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] care,
                           input logic [15:0] pol, input logic [7:0] om);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_op = op; cfg_addr = addr; cfg_care = care; cfg_pol = pol; cfg_omask = om;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout: actual=cfg_ready 0 expected=1");
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic apply_phase(input int p);
        int t0, n;
        t0 = cyc;
        n = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == p) begin
                send_vec(vecs[i].data, vecs[i].exp_out, vecs[i].exp_cnt);
                n++;
            end
        end
        chk($sformatf("throughput_p%0d", p), cyc - t0, n);
        drain();
    endtask

    task automatic b_cfg(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] care,
                         input logic [15:0] pol, input logic [7:0] om);
        int n;
        n = 0;
        b_cfg_valid = 1'b1;
        b_cfg_op = op; b_cfg_addr = addr; b_cfg_care = care; b_cfg_pol = pol; b_cfg_omask = om;
        @(negedge clk);
        while (!b_cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_cfg_ready", b_cfg_ready, 1);
        @(posedge clk);
        #1 b_cfg_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic b_vec(input logic [15:0] d, input logic [7:0] eo, input logic [4:0] ec);
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(negedge clk);
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_out_data", b_out_data, eo);
        chk("b_match_cnt", b_out_match_cnt, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: cube0 care 0003/pol 0001/om 01; cube5 care 0001/pol 0001/om 81;
        // cube31 care F000/pol A000/om 10; out_pol 80 from phase 3.
        vecs[0]  = '{2, 16'h0001, 8'h01, 6'd1};
        vecs[1]  = '{2, 16'h0003, 8'h00, 6'd0};
        vecs[2]  = '{3, 16'h0001, 8'h01, 6'd2};
        vecs[3]  = '{3, 16'h0000, 8'h80, 6'd0};
        vecs[4]  = '{3, 16'h0005, 8'h01, 6'd2};
        vecs[5]  = '{3, 16'h0002, 8'h80, 6'd0};
        vecs[6]  = '{3, 16'hFFFF, 8'h01, 6'd1};
        vecs[7]  = '{3, 16'h0003, 8'h01, 6'd1};
        vecs[8]  = '{3, 16'hA000, 8'h90, 6'd1};
        vecs[9]  = '{3, 16'hA001, 8'h11, 6'd3};
        vecs[10] = '{4, 16'h0001, 8'h81, 6'd1};
        vecs[11] = '{5, 16'h0001, 8'h80, 6'd0};
        vecs[12] = '{5, 16'hFFFF, 8'h80, 6'd0};
        vecs[13] = '{6, 16'h0001, 8'h00, 6'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_match_cnt", out_match_cnt, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Empty table, latency of two cycles
        exp_q.push_back({8'h00, 6'd0});
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(negedge clk);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t1_out_valid_t1", out_valid, 0);
        @(negedge clk);
        chk("t1_out_valid_t2", out_valid, 1);
        drain();

        cfg_cmd(2'b00, 5'd0, 16'h0003, 16'h0001, 8'h01);
        apply_phase(2);

        cfg_cmd(2'b00, 5'd5, 16'h0001, 16'h0001, 8'h81);
        cfg_cmd(2'b01, 5'd0, 16'h0000, 16'h0000, 8'h80);
        cfg_cmd(2'b00, 5'd31, 16'hF000, 16'hA000, 8'h10);
        apply_phase(3);

        cfg_cmd(2'b11, 5'd5, 16'h0000, 16'h0000, 8'h00);
        apply_phase(4);

        // Backpressure: two vectors fit, the third waits for out_ready
        out_ready = 1'b0;
        exp_q.push_back({8'h81, 6'd1});
        exp_q.push_back({8'h91, 6'd2});
        exp_q.push_back({8'h80, 6'd0});
        rx0 = rx_cnt;
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(negedge clk);
        chk("bp_accept0", in_ready, 1);
        @(posedge clk);
        #1 in_data = 16'hA001;
        @(negedge clk);
        chk("bp_accept1", in_ready, 1);
        @(posedge clk);
        #1 in_data = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_in_ready", in_ready, 0);
        end
        chk("bp_cfg_ready", cfg_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("bp_all_results", rx_cnt - rx0, 3);

        // Config has priority over a simultaneously offered vector
        exp_q.push_back({8'h80, 6'd0});
        cfg_valid = 1'b1; cfg_op = 2'b01; cfg_omask = 8'h80;
        in_valid  = 1'b1; in_data = 16'h0000;
        @(negedge clk);
        chk("prio_in_ready", in_ready, 0);
        chk("prio_cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        chk("prio_in_after", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // CLEAR sweep
        cfg_cmd(2'b10, 5'd0, 16'h0000, 16'h0000, 8'h00);
        busy_cnt = 0;
        blk_bad  = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (in_ready || cfg_ready) blk_bad++;
        end
        chk("clear_busy_cycles", busy_cnt, 32);
        chk("clear_blocks_handshakes", blk_bad, 0);
        @(posedge clk);
        #1;
        apply_phase(5);

        // Reset in the middle of a CLEAR
        cfg_cmd(2'b10, 5'd0, 16'h0000, 16'h0000, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid_clear", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_match_cnt", out_match_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        apply_phase(6);
        chk("main_no_cfg_err", err_pulses, 0);

        // 24-cube instance: out-of-range addresses
        b_cfg(2'b00, 5'd3, 16'h000F, 16'h0005, 8'h42);
        b_vec(16'h0005, 8'h42, 5'd1);
        b_vec(16'h0004, 8'h00, 5'd0);
        b_cfg_valid = 1'b1;
        b_cfg_op = 2'b00; b_cfg_addr = 5'd30; b_cfg_care = '0; b_cfg_pol = '0; b_cfg_omask = 8'hFF;
        @(negedge clk);
        chk("b_bad_addr_ready", b_cfg_ready, 1);
        chk("b_err_before", b_cfg_err, 0);
        @(posedge clk);
        #1 b_cfg_valid = 1'b0;
        @(negedge clk);
        chk("b_err_pulse", b_cfg_err, 1);
        @(negedge clk);
        chk("b_err_drop", b_cfg_err, 0);
        @(posedge clk);
        #1;
        b_vec(16'h0005, 8'h42, 5'd1);
        b_vec(16'h0000, 8'h00, 5'd0);
        b_cfg(2'b11, 5'd24, 16'h0000, 16'h0000, 8'h00);
        b_vec(16'h0005, 8'h42, 5'd1);
        b_cfg(2'b00, 5'd23, 16'h0000, 16'h0000, 8'h01);
        b_vec(16'h0000, 8'h01, 5'd1);
        b_vec(16'h0005, 8'h43, 5'd2);
        b_cfg(2'b11, 5'd3, 16'h0000, 16'h0000, 8'h00);
        b_vec(16'h0005, 8'h01, 5'd1);
        chk("b_err_pulse_count", b_err_pulses, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
